shift_scheduler: RTL and testbench
==================================

SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits.
REQ-002 Parameter DIST_W, default 4, shift-distance field width in bits.
REQ-003 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port req0_valid  input  1  requester 0 has a shift job pending.
REQ-006 Port req0_value  input  WIDTH  requester 0 operand.
REQ-007 Port req0_dist  input  DIST_W  requester 0 right-shift distance.
REQ-008 Port req0_ready  output  1  requester 0 job accepted this cycle.
REQ-009 Ports req1_valid, req1_value, req1_dist, req1_ready SHALL mirror REQ-005..REQ-008 for requester 1.
REQ-010 Port res_valid  output  1  result available.
REQ-011 Port res_ready  input  1  consumer accepts result.
REQ-012 Port res_value  output  WIDTH  shifted result.
REQ-013 Port res_id  output  1  index of the requester that owns the result.
REQ-014 Port busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL be an FSM with states IDLE, SHIFT and DONE.
REQ-016 In IDLE, the grant SHALL be combinational: one valid requester gets reqN_ready=1; if both are valid, the requester named by the round-robin pointer wins.
REQ-017 reqN_ready SHALL be 0 in SHIFT and DONE, and SHALL never be 1 for both requesters in the same cycle.
REQ-018 A job SHALL be accepted on the edge where reqN_valid and reqN_ready are both 1. On that edge the block latches value and id, and loads count = min(dist, WIDTH).
REQ-019 On acceptance, the round-robin pointer SHALL move to the requester that was not granted.
REQ-020 On acceptance, the FSM SHALL go to SHIFT if count>0, and to DONE if count==0.
REQ-021 Each SHIFT edge SHALL apply a logical right shift by 1 with zero fill and decrement count. When count==1 on that edge, the FSM SHALL go to DONE.
REQ-022 Latency SHALL be min(dist,WIDTH)+1 edges from the accept edge to res_valid=1.
REQ-023 In DONE, res_valid SHALL be 1, and res_value and res_id SHALL stay stable until res_ready=1. The handshake edge SHALL return the FSM to IDLE.
REQ-024 A new job SHALL be accepted no earlier than the cycle after the result handshake (no overlap).
REQ-025 A distance of WIDTH or more SHALL yield res_value=0 after WIDTH shift cycles.
REQ-026 res_value and res_id SHALL be don't-care when res_valid=0, but SHALL be driven and contain no X.

Reset
REQ-027 Asserting reset_n=0 SHALL immediately force the following, including mid-SHIFT or mid-DONE, where the in-flight job is discarded:
- state = IDLE
- pointer = requester 0
- count = 0
- res_valid = 0, res_value = 0, res_id = 0
- busy = 0
- req0_ready and req1_ready SHALL depend only on reqN_valid and the pointer.
REQ-028 After reset_n deasserts, the first simultaneous request SHALL be granted to requester 0.

Structure
REQ-029 The FSM state encoding and the WIDTH/DIST_W defaults SHALL live in a shared package/header.
REQ-030 The round-robin arbiter SHALL be a single sub-module named rr_arbiter2 (inputs: valid pair and pointer; outputs: one-hot grant). The shift datapath SHALL stay inline.

Verification
REQ-031 req0: value 1010, dist 2, res_ready=1 -> res_valid 3 edges after accept, res_value 0010, res_id 0.
REQ-032 req1: value 0110, dist 0 -> res_valid on the edge after accept, res_value 0110, res_id 1.
REQ-033 Both requesters valid continuously, values 1111/1000, dist 1 -> grants alternate 0,1,0,1 with results 0111, 0100, 0111, 0100.
REQ-034 req0: value 1111, dist 9 -> res_value 0000 after 4 shift cycles (latency 5).
REQ-035 Result held with res_ready=0 for 5 cycles -> res_value, res_id and res_valid stay constant, both reqN_ready stay 0, and the FSM returns to IDLE on the edge where res_ready=1.
REQ-036 reset_n pulsed low during SHIFT of a dist-3 job -> res_valid=0, busy=0, and the next simultaneous request is granted to requester 0.

Source files
------------

// File: rtl/shift_scheduler_pkg.sv
// Shared definitions for the shift scheduler: FSM state encoding and
// default datapath widths.
package shift_scheduler_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_DIST_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: pointer names the requester that wins a tie.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    // One-hot grant; a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        grant    = '0;
        grant[0] = valid[0] & (~valid[1] | ~pointer);
        grant[1] = valid[1] & (~valid[0] |  pointer);
    end

endmodule

// File: rtl/shift_scheduler.sv
// Two-requester serial right-shifter. A granted job is latched, shifted
// one bit per cycle min(dist, WIDTH) times, then held until the consumer
// takes it.
module shift_scheduler
    import shift_scheduler_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIST_W = DEF_DIST_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [WIDTH-1:0]  req0_value,
    input  logic [DIST_W-1:0] req0_dist,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WIDTH-1:0]  req1_value,
    input  logic [DIST_W-1:0] req1_dist,
    output logic              req1_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_value,
    output logic              res_id,
    output logic              busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t            state;
    logic              pointer;
    logic [WIDTH-1:0]  data;
    logic              id;
    logic [CNT_W-1:0]  count;
    logic [1:0]        grant;
    logic [DIST_W-1:0] sel_dist;
    logic [CNT_W-1:0]  load_cnt;

    rr_arbiter2 u_arb (
        .valid   ({req1_valid, req0_valid}),
        .pointer (pointer),
        .grant   (grant)
    );

    // Grants are only offered while idle; reset forces IDLE so they then
    // follow valid and the pointer alone.
    always_comb begin
        req0_ready = (state == IDLE) & grant[0];
        req1_ready = (state == IDLE) & grant[1];
    end

    // Shift count for the winning job, saturated at WIDTH since further
    // shifts cannot change an all-zero word.
    always_comb begin
        sel_dist = grant[1] ? req1_dist : req0_dist;
        if (32'(sel_dist) >= WIDTH) begin
            load_cnt = CNT_W'(WIDTH);
        end else begin
            load_cnt = CNT_W'(sel_dist);
        end
    end

    assign res_value = data;
    assign res_id    = id;

    // Control FSM and shift datapath with registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pointer   <= 1'b0;
            data      <= '0;
            id        <= 1'b0;
            count     <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        data    <= grant[1] ? req1_value : req0_value;
                        id      <= grant[1];
                        count   <= load_cnt;
                        pointer <= ~grant[1];
                        busy    <= 1'b1;
                        if (load_cnt == '0) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data  <= data >> 1;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_scheduler.sv
// Bench for shift_scheduler: directed jobs with literal expectations plus a
// randomized phase, all outputs compared every cycle against a job-level model.
module tb_shift_scheduler;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic [3:0] req0_value = '0;
    logic [3:0] req0_dist = '0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [3:0] req1_value = '0;
    logic [3:0] req1_dist = '0;
    logic       req1_ready;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_value;
    logic       res_id;
    logic       busy;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Job-level model: one job in flight, result known at accept time,
    // remaining cycles until the result shows up.
    bit         m_busy = 1'b0;
    bit         m_ptr = 1'b0;
    bit         m_id = 1'b0;
    logic [3:0] m_res = '0;
    int         m_rem = 0;

    shift_scheduler #(.WIDTH(4), .DIST_W(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_value (req0_value),
        .req0_dist  (req0_dist),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_value (req1_value),
        .req1_dist  (req1_dist),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_value  (res_value),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model across
    // the coming rising edge.
    always @(negedge clock) begin
        bit eg0, eg1;
        int sh;
        logic [3:0] v;
        if (!reset_n) begin
            m_busy = 1'b0;
            m_ptr  = 1'b0;
            m_rem  = 0;
        end
        if (!m_busy) begin
            eg0 = req0_valid && (!req1_valid || !m_ptr);
            eg1 = req1_valid && (!req0_valid || m_ptr);
        end else begin
            eg0 = 1'b0;
            eg1 = 1'b0;
        end
        check("ready0", req0_ready, eg0);
        check("ready1", req1_ready, eg1);
        check("busy", busy, m_busy);
        check("res_valid", res_valid, m_busy && m_rem == 0);
        check("res_known", $isunknown({res_value, res_id}), 0);
        if (!reset_n) begin
            check("rst_value", res_value, 0);
            check("rst_id", res_id, 0);
        end else if (m_busy && m_rem == 0) begin
            check("res_value", res_value, m_res);
            check("res_id", res_id, m_id);
        end
        if (reset_n) begin
            if (!m_busy) begin
                if (eg0 || eg1) begin
                    m_id   = eg1;
                    v      = eg1 ? req1_value : req0_value;
                    sh     = eg1 ? int'(req1_dist) : int'(req0_dist);
                    sh     = (sh > 4) ? 4 : sh;
                    m_res  = v >> sh;
                    m_rem  = sh;
                    m_busy = 1'b1;
                    m_ptr  = !eg1;
                end
            end else if (m_rem > 0) begin
                m_rem--;
            end else if (res_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // Submit one job, measure edges from accept to res_valid, optionally
    // hold the result with both requesters asserting, then hand it off.
    task automatic run_job(input string name,
                           input logic v0, input logic [3:0] a0, input logic [3:0] d0,
                           input logic v1, input logic [3:0] a1, input logic [3:0] d1,
                           input logic exp_id, input logic [3:0] exp_val,
                           input int exp_lat, input int hold);
        int n;
        int lat;
        req0_valid = v0; req0_value = a0; req0_dist = d0;
        req1_valid = v1; req1_value = a1; req1_dist = d1;
        res_ready  = 1'b0;
        n = 0;
        @(negedge clock);
        while (!((req0_valid && req0_ready) || (req1_valid && req1_ready)) && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({name, "_grant_seen"}, n < 40, 1);
        check({name, "_grant_id"}, req1_ready, exp_id);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_value"}, res_value, exp_val);
        check({name, "_id"}, res_id, exp_id);
        for (int i = 0; i < hold; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            @(posedge clock); #1;
            check({name, "_hold_valid"}, res_valid, 1);
            check({name, "_hold_value"}, res_value, exp_val);
            check({name, "_hold_id"}, res_id, exp_id);
            check({name, "_hold_ready"}, {req0_ready, req1_ready}, 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0;
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_valid"}, res_valid, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_valid", res_valid, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        run_job("dist2",  1'b1, 4'b1010, 4'd2, 1'b0, 4'b0000, 4'd0, 1'b0, 4'b0010, 3, 0);
        run_job("dist0",  1'b0, 4'b0000, 4'd0, 1'b1, 4'b0110, 4'd0, 1'b1, 4'b0110, 1, 0);
        run_job("rr_a",   1'b1, 4'b1111, 4'd1, 1'b1, 4'b1000, 4'd1, 1'b0, 4'b0111, 2, 0);
        run_job("rr_b",   1'b1, 4'b1111, 4'd1, 1'b1, 4'b1000, 4'd1, 1'b1, 4'b0100, 2, 0);
        run_job("rr_c",   1'b1, 4'b1111, 4'd1, 1'b1, 4'b1000, 4'd1, 1'b0, 4'b0111, 2, 0);
        run_job("rr_d",   1'b1, 4'b1111, 4'd1, 1'b1, 4'b1000, 4'd1, 1'b1, 4'b0100, 2, 0);
        run_job("dist9",  1'b1, 4'b1111, 4'd9, 1'b0, 4'b0000, 4'd0, 1'b0, 4'b0000, 5, 0);
        run_job("hold5",  1'b0, 4'b0000, 4'd0, 1'b1, 4'b1001, 4'd1, 1'b1, 4'b0100, 2, 5);

        // Reset in the middle of a dist-3 job after the pointer has moved to 1.
        req0_valid = 1'b1; req0_value = 4'b1011; req0_dist = 4'd3;
        @(posedge clock); #1;
        req0_valid = 1'b0;
        @(posedge clock); #1;
        check("mid_shift_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rst_shift_valid", res_valid, 0);
        check("rst_shift_busy", busy, 0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clock); #1;
        reset_n = 1'b1;
        run_job("post_rst", 1'b1, 4'b0101, 4'd0, 1'b1, 4'b1110, 4'd0, 1'b0, 4'b0101, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req0_value = 4'($urandom);
            req0_dist  = 4'($urandom);
            req1_valid = 1'($urandom_range(0, 1));
            req1_value = 4'($urandom);
            req1_dist  = 4'($urandom);
            res_ready  = ($urandom_range(0, 3) != 0);
            reset_n    = ($urandom_range(0, 99) != 0);
            @(posedge clock); #1;
        end
        reset_n    = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clock); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
